// File: rtl/uart_link_pkg.sv
// Shared types for the UART link blocks: arbiter state encoding and default byte width.
package uart_link_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, searching
// upward with wrap. Shared by the TX arbiter and the RX dispatcher.
module rr_pick
    import uart_link_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        int pos;
        logic [PW-1:0] cand;
        pos   = 0;
        cand  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = PW'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the UART TX FIFO write port between
// NUM_REQ byte-stream requesters, with a per-grant beat watchdog.
module uart_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 3,
    parameter int MAX_FRAME  = 16,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(MAX_FRAME + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          abort_pulse
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          abort_q, abort_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          beat;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        abort_d    = 1'b0;
        out_data   = '0;
        out_valid  = 1'b0;
        req_ready  = '0;
        beat       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (ena && pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id_q == IW'(i)) begin
                        out_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                out_valid             = req_valid[grant_id_q] & ena;
                req_ready[grant_id_q] = out_ready & ena;
                beat                  = out_valid & out_ready;
                // A last byte always wins over the watchdog, so a frame of exactly
                // MAX_FRAME beats ends cleanly without an abort.
                if (beat) begin
                    if (req_last[grant_id_q] || (beat_cnt_q == CW'(MAX_FRAME - 1))) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);
                        beat_cnt_d = '0;
                        abort_d    = ~req_last[grant_id_q];
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_id    = grant_id_q;
    assign busy        = (state_q == ARB_GRANT);
    assign abort_pulse = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle reference model plus directed
// frame scenarios checked against hand-written beat sequences.
module tb_uart_tx_arbiter;

    localparam int DW        = 8;
    localparam int NR        = 3;
    localparam int MAX_FRAME = 4;

    logic            clk;
    logic            reset;
    logic            ena;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            abort_pulse;

    int checks = 0;
    int errors = 0;
    int abort_seen = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];

    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_beats;
    bit m_abort;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_FRAME(MAX_FRAME)) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .abort_pulse (abort_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] d, input logic last);
        case (id)
            0: q0.push_back({last, d});
            1: q1.push_back({last, d});
            default: q2.push_back({last, d});
        endcase
    endtask

    task automatic expect_beat(input int id, input logic [7:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    task automatic drive_src();
        req_valid[0]    = (q0.size() != 0);
        req_data[7:0]   = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        req_last[0]     = (q0.size() != 0) ? q0[0][8] : 1'b0;
        req_valid[1]    = (q1.size() != 0);
        req_data[15:8]  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        req_last[1]     = (q1.size() != 0) ? q1[0][8] : 1'b0;
        req_valid[2]    = (q2.size() != 0);
        req_data[23:16] = (q2.size() != 0) ? q2[0][7:0] : 8'h00;
        req_last[2]     = (q2.size() != 0) ? q2[0][8] : 1'b0;
    endtask

    // Requester sources: a byte is retired on the edge where its ready was seen.
    initial begin
        logic [NR-1:0] acc;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() != 0) void'(q0.pop_front());
            if (acc[1] && q1.size() != 0) void'(q1.pop_front());
            if (acc[2] && q2.size() != 0) void'(q2.pop_front());
            drive_src();
        end
    end

    // Reference model: grant owner, rotation pointer, beats in the current grant.
    initial begin
        bit picked;
        bit abort_nxt;
        int cand;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_abort = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_abort = 0;
            end else begin
                abort_nxt = 0;
                if (!m_busy) begin
                    picked = 0;
                    if (ena) begin
                        for (int k = 0; k < NR; k++) begin
                            cand = (m_ptr + k) % NR;
                            if (!picked && req_valid[cand]) begin
                                picked  = 1;
                                m_owner = cand;
                                m_busy  = 1;
                            end
                        end
                    end
                end else if (ena && req_valid[m_owner] && out_ready) begin
                    m_beats = m_beats + 1;
                    if (req_last[m_owner] || m_beats == MAX_FRAME) begin
                        abort_nxt = !req_last[m_owner];
                        m_busy    = 0;
                        m_ptr     = (m_owner + 1) % NR;
                        m_beats   = 0;
                    end
                end
                m_abort = abort_nxt;
            end
        end
    end

    // Per-cycle comparison against the model, and a log of the beats the DUT emitted.
    initial begin
        logic [7:0]    e_data;
        logic [NR-1:0] e_ready;
        bit            e_valid;
        forever begin
            @(negedge clk);
            e_valid = m_busy && ena && req_valid[m_owner];
            e_data  = m_busy ? req_data[m_owner*DW +: DW] : 8'h00;
            e_ready = (m_busy && ena && out_ready) ? NR'(1 << m_owner) : '0;
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("grant_id", 32'(grant_id), 32'(m_owner));
            checkOutput("out_valid", 32'(out_valid), 32'(e_valid));
            checkOutput("out_data", 32'(out_data), 32'(e_data));
            checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
            checkOutput("abort_pulse", 32'(abort_pulse), 32'(m_abort));
            if (!reset && out_valid === 1'b1 && out_ready) log_q.push_back({grant_id, out_data});
            if (abort_pulse === 1'b1) abort_seen++;
        end
    end

    task automatic wait_log(input int n, input string name);
        int cyc = 0;
        while (log_q.size() < n && cyc < 200) begin
            sync();
            cyc++;
        end
        if (log_q.size() < n) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        bit done = 0;
        while (!done && cyc < 200) begin
            sync();
            cyc++;
            done = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && (busy === 1'b0);
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_busy(input string name);
        int cyc = 0;
        while (busy !== 1'b1 && cyc < 50) begin
            sync();
            cyc++;
        end
        if (busy !== 1'b1) timeout_fail(name);
    endtask

    task automatic check_log(input string name);
        checkOutput($sformatf("%s beat count", name), 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) checkOutput($sformatf("%s beat %0d", name, i), 32'(log_q[i]), 32'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int cyc;
        reset     = 1'b1;
        ena       = 1'b1;
        out_ready = 1'b1;
        sync();
        sync();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset abort", 32'(abort_pulse), 32'd0);
        reset = 1'b0;
        sync();

        // Single req0 frame.
        log_q.delete();
        applyStimulus(0, 8'h41, 0);
        applyStimulus(0, 8'h42, 0);
        applyStimulus(0, 8'h43, 1);
        cyc = 0;
        while (req_valid[0] !== 1'b1 && cyc < 10) begin
            sync();
            cyc++;
        end
        checkOutput("t1 busy before grant", 32'(busy), 32'd0);
        sync();
        checkOutput("t1 busy one cycle after valid", 32'(busy), 32'd1);
        checkOutput("t1 grant_id", 32'(grant_id), 32'd0);
        wait_log(3, "t1 beats");
        sync();
        checkOutput("t1 busy after last", 32'(busy), 32'd0);
        expect_beat(0, 8'h41); expect_beat(0, 8'h42); expect_beat(0, 8'h43);
        check_log("t1");

        // Pointer at 1: req1 beats req0, then req2 alone moves the pointer back to 0.
        applyStimulus(0, 8'h10, 1);
        applyStimulus(1, 8'h11, 1);
        wait_idle("t2a idle");
        applyStimulus(2, 8'h12, 1);
        wait_idle("t2b idle");
        expect_beat(1, 8'h11); expect_beat(0, 8'h10); expect_beat(2, 8'h12);
        check_log("t2 rotation");

        // Three simultaneous 2-byte frames, then req0 ahead of req1.
        applyStimulus(0, 8'hA0, 0); applyStimulus(0, 8'hA1, 1);
        applyStimulus(1, 8'hB0, 0); applyStimulus(1, 8'hB1, 1);
        applyStimulus(2, 8'hC0, 0); applyStimulus(2, 8'hC1, 1);
        wait_idle("t2c idle");
        applyStimulus(1, 8'hB2, 1);
        applyStimulus(0, 8'hA2, 1);
        wait_idle("t2d idle");
        expect_beat(0, 8'hA0); expect_beat(0, 8'hA1);
        expect_beat(1, 8'hB0); expect_beat(1, 8'hB1);
        expect_beat(2, 8'hC0); expect_beat(2, 8'hC1);
        expect_beat(0, 8'hA2); expect_beat(1, 8'hB2);
        check_log("t2 all");

        // Backpressure during a req1 frame.
        applyStimulus(1, 8'h55, 0);
        applyStimulus(1, 8'hAA, 1);
        wait_busy("t3 grant");
        @(posedge clk); #1 out_ready = 1'b0;
        sync();
        checkOutput("t3 held data a", 32'(out_data), 32'h0AA);
        checkOutput("t3 held valid a", 32'(out_valid), 32'd1);
        @(posedge clk);
        sync();
        checkOutput("t3 held data b", 32'(out_data), 32'h0AA);
        checkOutput("t3 ready low", 32'(req_ready), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle("t3 idle");
        expect_beat(1, 8'h55); expect_beat(1, 8'hAA);
        check_log("t3");

        // Watchdog: req2 streams 6 bytes without last while req0 waits.
        abort_seen = 0;
        for (int i = 0; i < 6; i++) applyStimulus(2, 8'(8'h60 + i), 0);
        applyStimulus(0, 8'h70, 1);
        wait_log(7, "t4 beats");
        sync();
        sync();
        checkOutput("t4 abort count", 32'(abort_seen), 32'd1);
        checkOutput("t4 still held", 32'(busy), 32'd1);
        checkOutput("t4 held grant", 32'(grant_id), 32'd2);
        checkOutput("t4 no valid", 32'(out_valid), 32'd0);
        expect_beat(2, 8'h60); expect_beat(2, 8'h61); expect_beat(2, 8'h62); expect_beat(2, 8'h63);
        expect_beat(0, 8'h70); expect_beat(2, 8'h64); expect_beat(2, 8'h65);
        check_log("t4");
        reset = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        sync();
        sync();
        reset = 1'b0;

        // Reset in the middle of a req1 frame.
        applyStimulus(1, 8'h90, 0); applyStimulus(1, 8'h91, 0);
        applyStimulus(1, 8'h92, 0); applyStimulus(1, 8'h93, 1);
        wait_log(2, "t5 beats");
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5 busy on reset", 32'(busy), 32'd0);
        checkOutput("t5 valid on reset", 32'(out_valid), 32'd0);
        checkOutput("t5 grant on reset", 32'(grant_id), 32'd0);
        q1.delete();
        sync();
        sync();
        reset = 1'b0;
        sync();
        sync();
        expect_beat(1, 8'h90); expect_beat(1, 8'h91);
        check_log("t5");

        // A frame of exactly MAX_FRAME beats ends on last with no abort.
        abort_seen = 0;
        applyStimulus(1, 8'h94, 0); applyStimulus(1, 8'h95, 0);
        applyStimulus(1, 8'h96, 0); applyStimulus(1, 8'h97, 1);
        wait_idle("t5b idle");
        sync();
        checkOutput("t5b abort count", 32'(abort_seen), 32'd0);
        expect_beat(1, 8'h94); expect_beat(1, 8'h95); expect_beat(1, 8'h96); expect_beat(1, 8'h97);
        check_log("t5b");

        // Enable dropped for five cycles in the middle of a req0 frame.
        abort_seen = 0;
        applyStimulus(0, 8'hD0, 0); applyStimulus(0, 8'hD1, 0);
        applyStimulus(0, 8'hD2, 0); applyStimulus(0, 8'hD3, 1);
        wait_log(2, "t6 beats");
        @(posedge clk);
        #1 ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync();
            checkOutput($sformatf("t6 frozen busy %0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("t6 frozen valid %0d", i), 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1 ena = 1'b1;
        wait_idle("t6 idle");
        sync();
        checkOutput("t6 abort count", 32'(abort_seen), 32'd0);
        expect_beat(0, 8'hD0); expect_beat(0, 8'hD1); expect_beat(0, 8'hD2); expect_beat(0, 8'hD3);
        check_log("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
